// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - serial byte-stream loader that writes instruction words into imem
module boot_loader #(
  parameter int MAX_WORDS  = 65536,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        stall,
  output logic [31:0] ld_op32,
  output logic [29:0] ld_addr,
  output logic        ld_mwe,
  output logic        boot_busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] k_q, k_d;
  logic [31:0] ld_op32_q, ld_op32_d;
  logic [29:0] ld_addr_q, ld_addr_d;
  logic        ld_mwe_q, ld_mwe_d;
  logic        boot_busy_q, boot_busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic        fifo_empty, fifo_full, pop, push;
  logic [7:0]  pop_byte;
  logic [31:0] len_next, word_next;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    push       = rx_valid && (state_q != S_DONE) && (!fifo_full || pop);
    pop_byte   = fifo_mem[rd_ptr_q[AW-1:0]];
    len_next   = {pop_byte, len_q[31:8]};
    word_next  = {pop_byte, word_q[31:8]};

    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    word_d      = word_q;
    sum_d       = sum_q;
    k_d         = k_q;
    ld_op32_d   = ld_op32_q;
    ld_addr_d   = ld_addr_q;
    ld_mwe_d    = ld_mwe_q;
    boot_busy_d = boot_busy_q;
    done_d      = done_q;
    err_d       = err_q;
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};

    if (rx_valid && state_q != S_DONE && fifo_full && !pop) err_d = 1'b1;

    case (state_q)
      S_LEN: if (pop) begin
        len_d = len_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (len_next == 32'd0) begin
            state_d = S_CSUM;
          end else if (len_next > 32'(MAX_WORDS)) begin
            err_d       = 1'b1;
            done_d      = 1'b1;
            boot_busy_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: if (pop) begin
        word_d = word_next;
        sum_d  = sum_q + pop_byte;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          ld_mwe_d  = 1'b1;
          ld_op32_d = word_next;
          ld_addr_d = {5'b11110, 9'b0, k_q[15:0]};
          state_d   = S_WRITE;
        end
      end
      S_WRITE: if (!stall) begin
        ld_mwe_d = 1'b0;
        k_d      = k_q + 32'd1;
        state_d  = (k_q + 32'd1 == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (pop) begin
        if (pop_byte != sum_q) err_d = 1'b1;
        done_d      = 1'b1;
        boot_busy_d = 1'b0;
        state_d     = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN;
      cnt_q       <= 2'd0;
      len_q       <= 32'd0;
      word_q      <= 32'd0;
      sum_q       <= 8'd0;
      k_q         <= 32'd0;
      ld_op32_q   <= 32'd0;
      ld_addr_q   <= 30'd0;
      ld_mwe_q    <= 1'b0;
      boot_busy_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      k_q         <= k_d;
      ld_op32_q   <= ld_op32_d;
      ld_addr_q   <= ld_addr_d;
      ld_mwe_q    <= ld_mwe_d;
      boot_busy_q <= boot_busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign ld_op32   = ld_op32_q;
  assign ld_addr   = ld_addr_q;
  assign ld_mwe    = ld_mwe_q;
  assign boot_busy = boot_busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
